// File: rtl/mem_access_ctrl.sv
// Sequencer/arbiter for the single unified memory port of the multi-cycle CPU.
// Serialises fetch and load/store requests, data first, with a fixed access latency.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] pc,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic [31:0] mdr,
  output logic        if_done,
  output logic        ls_done,
  output logic        ls_err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_inst;
  logic [31:0] r_mdr;
  logic        r_we;
  logic        r_fetch;
  logic        r_err;

  logic w_access;
  logic w_done;
  logic w_last;
  logic w_misalign;

  assign w_access   = (r_state == S_ACCESS);
  assign w_done     = (r_state == S_DONE);
  assign w_last     = w_access && (r_cnt == 4'd0);
  assign w_misalign = (ls_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_inst  <= 32'd0;
      r_mdr   <= 32'd0;
      r_we    <= 1'b0;
      r_fetch <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Data wins: it belongs to the older instruction already in MEM.
          if (ls_req) begin
            r_fetch <= 1'b0;
            r_we    <= ls_we;
            r_addr  <= ls_addr;
            r_wdata <= ls_wdata;
            if (w_misalign) begin
              r_err   <= 1'b1;
              r_cnt   <= 4'd0;
              r_state <= S_DONE;
            end else begin
              r_err   <= 1'b0;
              r_cnt   <= CNT_LOAD;
              r_state <= S_ACCESS;
            end
          end else if (if_req) begin
            r_fetch <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= pc;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_cnt   <= CNT_LOAD;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
            if (r_fetch)    r_inst <= mem_rdata;
            else if (!r_we) r_mdr  <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes and bus are decoded from registered state, so they are clean
  // and drop to zero immediately when reset returns the FSM to IDLE.
  assign mem_addr  = w_access ? r_addr : 32'd0;
  assign mem_re    = w_access && !r_we;
  assign mem_we    = w_last && r_we;
  assign mem_wdata = (w_access && r_we) ? r_wdata : 32'd0;

  assign inst    = r_inst;
  assign mdr     = r_mdr;
  assign if_done = w_done && r_fetch;
  assign ls_done = w_done && !r_fetch;
  assign ls_err  = w_done && !r_fetch && r_err;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: three instances (W=1,3,4) share stimulus,
// each scenario targets the instance whose latency it exercises.
module tb_mem_access_ctrl;

  localparam int I1 = 0;
  localparam int I3 = 1;
  localparam int I4 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] pc;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem_addr_o  [3];
  logic [31:0] mem_wdata_o [3];
  logic [31:0] inst_o      [3];
  logic [31:0] mdr_o       [3];
  logic        mem_re_o    [3];
  logic        mem_we_o    [3];
  logic        if_done_o   [3];
  logic        ls_done_o   [3];
  logic        ls_err_o    [3];
  logic        busy_o      [3];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_ctrl #(
      .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 3 : 4))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .pc       (pc),
      .ls_req   (ls_req),
      .ls_we    (ls_we),
      .ls_addr  (ls_addr),
      .ls_wdata (ls_wdata),
      .mem_addr (mem_addr_o[g]),
      .mem_re   (mem_re_o[g]),
      .mem_we   (mem_we_o[g]),
      .mem_wdata(mem_wdata_o[g]),
      .mem_rdata(mem_rdata),
      .inst     (inst_o[g]),
      .mdr      (mdr_o[g]),
      .if_done  (if_done_o[g]),
      .ls_done  (ls_done_o[g]),
      .ls_err   (ls_err_o[g]),
      .busy     (busy_o[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are then settled for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int ld_at, fd_at, overlap, seen_we, seen_done;
    logic [31:0] arb_mdr, arb_inst;

    // Reset with random inputs
    rst       = 1'b1;
    if_req    = 1'($urandom);
    pc        = $urandom;
    ls_req    = 1'($urandom);
    ls_we     = 1'($urandom);
    ls_addr   = $urandom;
    ls_wdata  = $urandom;
    mem_rdata = $urandom;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_addr%0d", k),  mem_addr_o[k],  32'h0);
      chk($sformatf("rst_wdata%0d", k), mem_wdata_o[k], 32'h0);
      chk($sformatf("rst_inst%0d", k),  inst_o[k],      32'h0);
      chk($sformatf("rst_mdr%0d", k),   mdr_o[k],       32'h0);
      chk($sformatf("rst_strb%0d", k),  {30'd0, mem_re_o[k], mem_we_o[k]}, 32'h0);
      chk($sformatf("rst_flags%0d", k),
          {28'd0, if_done_o[k], ls_done_o[k], ls_err_o[k], busy_o[k]}, 32'h0);
    end
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    pc = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; mem_rdata = 32'h0;
    rst = 1'b0;
    tick();
    chk("post_rst_busy", {31'd0, busy_o[I1]}, 32'h0);

    // Fetch on W=1
    if_req = 1'b1; pc = 32'h0000_0010; mem_rdata = 32'h8C22_0004;
    tick();
    chk("f_re",    {31'd0, mem_re_o[I1]}, 32'h1);
    chk("f_addr",  mem_addr_o[I1],        32'h10);
    chk("f_early", {31'd0, if_done_o[I1]}, 32'h0);
    tick();
    chk("f_done",  {31'd0, if_done_o[I1]}, 32'h1);
    chk("f_lsd",   {31'd0, ls_done_o[I1]}, 32'h0);
    chk("f_inst",  inst_o[I1],            32'h8C22_0004);
    chk("f_mdr",   mdr_o[I1],             32'h0);
    chk("f_re_off", {31'd0, mem_re_o[I1]}, 32'h0);
    if_req = 1'b0;
    tick();
    chk("f_idle",  {31'd0, busy_o[I1]},   32'h0);
    chk("f_hold",  inst_o[I1],            32'h8C22_0004);
    idle_wait(4);

    // Load on W=3
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("ld_re%0d", i),   {31'd0, mem_re_o[I3]}, 32'h1);
      chk($sformatf("ld_we%0d", i),   {31'd0, mem_we_o[I3]}, 32'h0);
      chk($sformatf("ld_addr%0d", i), mem_addr_o[I3],        32'h20);
      chk($sformatf("ld_nd%0d", i),   {31'd0, ls_done_o[I3]}, 32'h0);
    end
    tick();
    chk("ld_done", {31'd0, ls_done_o[I3]}, 32'h1);
    chk("ld_err",  {31'd0, ls_err_o[I3]},  32'h0);
    chk("ld_mdr",  mdr_o[I3],              32'hDEAD_BEEF);
    chk("ld_re_off", {31'd0, mem_re_o[I3]}, 32'h0);
    ls_req = 1'b0;
    tick();
    chk("ld_idle", {31'd0, busy_o[I3]},    32'h0);

    // Store on W=3; read data on the bus must not reach mdr
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h24; ls_wdata = 32'h1234_5678;
    mem_rdata = 32'hCAFE_F00D;
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk($sformatf("st_we%0d", i),   {31'd0, mem_we_o[I3]}, 32'h0);
      chk($sformatf("st_re%0d", i),   {31'd0, mem_re_o[I3]}, 32'h0);
      chk($sformatf("st_addr%0d", i), mem_addr_o[I3],        32'h24);
    end
    tick();
    chk("st_we3",    {31'd0, mem_we_o[I3]}, 32'h1);
    chk("st_re3",    {31'd0, mem_re_o[I3]}, 32'h0);
    chk("st_addr3",  mem_addr_o[I3],        32'h24);
    chk("st_wdata3", mem_wdata_o[I3],       32'h1234_5678);
    tick();
    chk("st_done",   {31'd0, ls_done_o[I3]}, 32'h1);
    chk("st_we_off", {31'd0, mem_we_o[I3]},  32'h0);
    chk("st_mdr",    mdr_o[I3],              32'hDEAD_BEEF);
    chk("st_wd_off", mem_wdata_o[I3],        32'h0);
    ls_req = 1'b0; ls_we = 1'b0;
    idle_wait(8);

    // Arbitration on W=3: load at 0x40 and fetch at 0x100 raised together
    ld_at = -1; fd_at = -1; overlap = 0;
    arb_mdr = 32'h0; arb_inst = 32'h0;
    if_req = 1'b1; pc = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; mem_rdata = 32'h1111_2222;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (mem_re_o[I3] && mem_we_o[I3]) overlap++;
      if (i == 1) chk("arb_first_addr", mem_addr_o[I3], 32'h40);
      if (ls_done_o[I3] && ld_at < 0) begin
        ld_at = i; arb_mdr = mdr_o[I3];
        ls_req = 1'b0; mem_rdata = 32'h3333_4444;
      end
      if (if_done_o[I3] && fd_at < 0) begin
        fd_at = i; arb_inst = inst_o[I3];
        if_req = 1'b0;
      end
    end
    chk("arb_ld_at",   32'(ld_at),   32'd4);
    chk("arb_fd_at",   32'(fd_at),   32'd9);
    chk("arb_mdr",     arb_mdr,      32'h1111_2222);
    chk("arb_inst",    arb_inst,     32'h3333_4444);
    chk("arb_overlap", 32'(overlap), 32'd0);
    if_req = 1'b0; ls_req = 1'b0;
    idle_wait(8);

    // Misaligned load on W=3
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0022; mem_rdata = 32'h5555_AAAA;
    tick();
    chk("mis_done", {31'd0, ls_done_o[I3]}, 32'h1);
    chk("mis_err",  {31'd0, ls_err_o[I3]},  32'h1);
    chk("mis_strb", {30'd0, mem_re_o[I3], mem_we_o[I3]}, 32'h0);
    chk("mis_mdr",  mdr_o[I3],              32'h1111_2222);
    ls_req = 1'b0;
    tick();
    chk("mis_clear", {29'd0, ls_done_o[I3], ls_err_o[I3], busy_o[I3]}, 32'h0);
    chk("mis_strb2", {30'd0, mem_re_o[I3], mem_we_o[I3]}, 32'h0);
    chk("mis_mdr2",  mdr_o[I3],             32'h1111_2222);
    idle_wait(8);

    // Reset in the 2nd ACCESS cycle of a W=4 store
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h80; ls_wdata = 32'hA5A5_A5A5;
    tick();
    chk("rm_we1",   {31'd0, mem_we_o[I4]}, 32'h0);
    tick();
    chk("rm_we2",   {31'd0, mem_we_o[I4]}, 32'h0);
    chk("rm_busy2", {31'd0, busy_o[I4]},   32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    chk("rm_idle",  {31'd0, busy_o[I4]},   32'h0);
    seen_we = 0; seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_we_o[I4])  seen_we++;
      if (ls_done_o[I4]) seen_done++;
      tick();
    end
    chk("rm_no_we",   32'(seen_we),   32'd0);
    chk("rm_no_done", 32'(seen_done), 32'd0);
    chk("rm_idle2",   {31'd0, busy_o[I4]}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer and arbiter for the single unified memory port of the multi-cycle CPU. It accepts instruction-fetch requests from the IF step and load/store requests from the MEM step. It serialises them onto one memory interface with a fixed read/write latency, and registers the returned word into the instruction register (`inst`) or the memory data register (`mdr`). It sits between the multi-cycle control FSM and the memory, and is the only block that drives memory address and strobes.

## Interface
- `WAIT_CYCLES`, default 1: access cycles per transaction; legal range 1..15.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; level, held by the requester until `if_done`.
- `pc`  in  32  fetch address; sampled when the fetch is granted.
- `ls_req`  in  1  load/store request; level, held until `ls_done`.
- `ls_we`  in  1  1 = store, 0 = load; sampled at grant.
- `ls_addr`  in  32  data address; sampled at grant.
- `ls_wdata`  in  32  store data; sampled at grant.
- `mem_addr`  out  32  memory address.
- `mem_re`  out  1  memory read strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; valid in the last access cycle.
- `inst`  out  32  instruction register.
- `mdr`  out  32  memory data register.
- `if_done`  out  1  one-cycle pulse: fetch complete, `inst` valid.
- `ls_done`  out  1  one-cycle pulse: load/store complete, or rejected.
- `ls_err`  out  1  valid with `ls_done`: misaligned address, no access performed.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE:**
  - If `ls_req` is high, grant data. Data has fixed priority over fetch because it belongs to the older instruction.
  - Otherwise, if `if_req` is high, grant fetch.
  - On grant, latch the address, write data and `ls_we` into internal registers, load the wait counter with `WAIT_CYCLES-1`, and go to ACCESS.
- **Misaligned data request** (`ls_addr[1:0] != 0`) in IDLE:
  - No ACCESS state; go straight to DONE with `ls_err=1`.
  - No memory strobe; `mdr` unchanged.
- **ACCESS:**
  - `mem_addr` is driven from the latched address.
  - For loads and fetches, `mem_re=1` in every ACCESS cycle.
  - For stores, `mem_we=1` only in the final ACCESS cycle (counter = 0), with `mem_wdata` = latched data; `mem_re=0`.
  - The counter decrements each cycle. When the counter is 0, go to DONE.
  - On that edge, capture `mem_rdata` into `inst` (fetch) or `mdr` (load). A store leaves `mdr` unchanged.
- **DONE:**
  - Pulse `if_done` or `ls_done` (plus `ls_err`) for exactly one cycle, then return to IDLE.
  - Requests are ignored while in DONE. The requester must drop its request on the edge that ends DONE.
  - A request still high in the following IDLE is treated as a new transaction.
- `inst` and `mdr` hold their value between transactions; only the matching transaction updates each one.
- `mem_addr` and `mem_wdata` are 0 outside ACCESS.

## Timing
- **Reset:**
  - State goes to IDLE.
  - These outputs are 0: `inst`, `mdr`, `mem_addr`, `mem_wdata`, `mem_re`, `mem_we`, `if_done`, `ls_done`, `ls_err`, `busy`.
  - The wait counter is 0.
  - Reset during ACCESS aborts the transaction: no done pulse, no further strobe, and no write if reset arrives before the final ACCESS cycle.
- **Latency:**
  - A request sampled in IDLE at cycle t gives ACCESS over t+1..t+W and DONE (pulse) at t+W+1, where W = `WAIT_CYCLES`.
  - The new `inst`/`mdr` value is visible in the DONE cycle.
- **Misaligned data request:** IDLE at cycle t, `ls_done` and `ls_err` at t+1.
- **Back-to-back:** the minimum spacing between grants is W+2 cycles.
- **Simultaneous `if_req` and `ls_req` in IDLE:** data is served first. The fetch is granted in the IDLE cycle after data's DONE.
- A request arriving during ACCESS or DONE waits; it is never lost while held.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs -> all outputs 0 and `busy=0`; release -> IDLE.
- **Fetch:**
  - Stimulus: W=1, `pc`=0x00000010, `mem_rdata`=0x8C220004.
  - Required: `mem_re`=1 and `mem_addr`=0x10 exactly one cycle after grant; `if_done` one cycle later with `inst`=0x8C220004; `mdr` unchanged.
- **Load and store:**
  - Stimulus: W=3; load from 0x20 returning 0xDEADBEEF, then store 0x12345678 to 0x24.
  - Required, load: `mem_re` high for 3 cycles; `ls_done` 4 cycles after grant; `mdr`=0xDEADBEEF.
  - Required, store: `mem_we` high only in the 3rd ACCESS cycle with `mem_addr`=0x24 and `mem_wdata`=0x12345678; `mdr` still 0xDEADBEEF.
- **Arbitration:**
  - Stimulus: raise `if_req` and `ls_req` (load, 0x40) in the same cycle.
  - Required: the load completes first; `if_done` arrives W+2 cycles after `ls_done`; no overlapping strobes.
- **Misaligned:**
  - Stimulus: `ls_addr`=0x00000022.
  - Required: `ls_done=1` and `ls_err=1` one cycle after IDLE sampling; `mem_re`, `mem_we` never asserted; `mdr` unchanged.
- **Reset mid-access:**
  - Stimulus: W=4 store; assert `rst` in the 2nd ACCESS cycle.
  - Required: `mem_we` never high, no `ls_done`, IDLE after reset.
